l2_param_array: RTL and testbench
=================================

// Module: l2_param_array
// PURPOSE
//  Parametrised single-port L2 way storage: WIDTH-bit lines, DEPTH entries, per-entry valid/dirty bits.
//  Byte-enable writes, 1-cycle registered reads and a sequential clear sweep after reset or on request.
//  One instance per way, below the L2 controller; the controller issues at most one op per cycle.
// PARAMETERS
//  WIDTH  128               line width in bits; multiple of 8
//  DEPTH  16                entries; power of two, >= 2
//  IDX_W  $clog2(DEPTH)     index width (derived; do not override)
// PORTS
//  clk          in   1        clock; all logic on posedge
//  rst_n        in   1        reset, synchronous, active-low
//  req_valid    in   1        op request
//  req_ready    out  1        array can accept an op this cycle
//  req_write    in   1        1 = write, 0 = read (when req_inval = 0)
//  req_inval    in   1        1 = invalidate entry (overrides req_write)
//  index        in   IDX_W    entry select
//  byte_en      in   WIDTH/8  write byte enables; bit i covers datain[8i+7:8i]
//  datain       in   WIDTH    write data
//  dirty_in     in   1        dirty value stored on write
//  clear_req    in   1        start a full clear sweep
//  rdata_valid  out  1        one-cycle pulse: dataout/valid_out/dirty_out hold read result
//  dataout      out  WIDTH    read data (registered)
//  valid_out    out  1        valid bit of entry read (registered)
//  dirty_out    out  1        dirty bit of entry read (registered)
// BEHAVIOUR
//  - States: CLEAR, READY. req_ready = (state == READY), combinational from state only.
//  - Reset (rst_n = 0 at posedge): state <= CLEAR, clr_cnt <= 0, rdata_valid <= 0, dataout <= 0,
//    valid_out <= 0, dirty_out <= 0. Storage is not reset directly; the sweep clears it.
//  - CLEAR: each cycle writes data = 0, valid = 0, dirty = 0 to entry clr_cnt, then clr_cnt++.
//    Cycle that clears entry DEPTH-1 -> READY next cycle. Sweep takes exactly DEPTH cycles;
//    req_ready first goes high DEPTH cycles after rst_n rises.
//  - Reset during CLEAR restarts the sweep at entry 0. clear_req is ignored while in CLEAR.
//  - Accept = req_valid & req_ready. Without accept, no storage change and no rdata_valid.
//  - Read accepted at cycle N: rdata_valid = 1 in cycle N+1 only, with dataout/valid_out/dirty_out
//    = contents of index as of cycle N. Outputs hold until the next read result.
//  - Write accepted: bytes with byte_en = 1 updated, others kept; valid <= 1, dirty <= dirty_in
//    (also when byte_en = 0). No rdata_valid.
//  - Invalidate accepted: valid <= 0, dirty <= 0, data unchanged. No rdata_valid.
//  - A read of an index written in the previous cycle returns the new data (storage updated at edge).
//  - clear_req in READY: state <= CLEAR, clr_cnt <= 0 next cycle. An op accepted in the same cycle
//    still completes; a read returns rdata_valid in the first CLEAR cycle.
//  - Accepted op with req_inval & req_write: treated as invalidate.
//  - No combinational path from any input to dataout, valid_out, dirty_out or rdata_valid.
// TESTING
//  1 rst_n low 2 cycles, then high -> req_ready = 0 for 16 cycles, then 1; a read of every index
//    returns valid_out = 0, dataout = 0.
//  2 write idx 3, byte_en all 1s, data 0x0123...CDEF, dirty_in = 1; read idx 3 next cycle
//    -> rdata_valid 1 cycle later, same data, valid_out = 1, dirty_out = 1.
//  3 write idx 5 with all-1s data, then write byte_en = 16'h0001, datain = 0 -> read gives
//    0xFF..FF00; a write with byte_en = 0, dirty_in = 0 leaves data unchanged, clears dirty.
//  4 invalidate idx 3 -> read: valid_out = 0, dirty_out = 0, data unchanged.
//  5 clear_req with a same-cycle read of idx 5 -> rdata_valid next cycle with the old data;
//    req_ready low 16 cycles; afterwards all entries read as zero and invalid.
//  6 rst_n low at cycle 7 of the sweep -> sweep restarts; req_ready high 16 cycles after release.
//    Reqs during CLEAR are not accepted; also run with WIDTH = 64, DEPTH = 8.

Source files
------------

// File: rtl/l2_param_array_if.sv
// Controller-to-way bundle for one L2 way storage array.
// Master is the L2 controller, slave is the array.
interface l2_param_array_if #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int BYTES = WIDTH / 8;

    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic             req_inval;
    logic [IDX_W-1:0] index;
    logic [BYTES-1:0] byte_en;
    logic [WIDTH-1:0] datain;
    logic             dirty_in;
    logic             clear_req;
    logic             rdata_valid;
    logic [WIDTH-1:0] dataout;
    logic             valid_out;
    logic             dirty_out;

    modport master (
        output req_valid, req_write, req_inval, index,
        output byte_en, datain, dirty_in, clear_req,
        input  req_ready, rdata_valid, dataout,
        input  valid_out, dirty_out
    );

    modport slave (
        input  req_valid, req_write, req_inval, index,
        input  byte_en, datain, dirty_in, clear_req,
        output req_ready, rdata_valid, dataout,
        output valid_out, dirty_out
    );
endinterface

// File: rtl/l2_param_array.sv
// One L2 way: byte-enable line storage with valid/dirty bits,
// registered reads and a sequential clear sweep.
module l2_param_array #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input logic               clk,
    input logic               rst_n,
    l2_param_array_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int BYTES = WIDTH / 8;

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] dirty_q;

    logic             rdata_valid_q;
    logic [WIDTH-1:0] dataout_q;
    logic             valid_out_q;
    logic             dirty_out_q;

    logic accept;
    logic rd_en;
    logic wr_en;
    logic inv_en;
    logic clr_en;

    assign bus.req_ready = (state_q == READY);
    assign accept        = bus.req_valid & bus.req_ready;
    assign inv_en        = accept & bus.req_inval;
    assign wr_en         = accept & ~bus.req_inval & bus.req_write;
    assign rd_en         = accept & ~bus.req_inval & ~bus.req_write;
    assign clr_en        = (state_q == CLEAR);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + IDX_W'(1);
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (bus.clear_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Storage has no reset of its own; the sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_q[clr_cnt_q]   <= '0;
            valid_q[clr_cnt_q] <= 1'b0;
            dirty_q[clr_cnt_q] <= 1'b0;
        end else if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.byte_en[b]) begin
                    mem_q[bus.index][8*b +: 8] <= bus.datain[8*b +: 8];
                end
            end
            valid_q[bus.index] <= 1'b1;
            dirty_q[bus.index] <= bus.dirty_in;
        end else if (inv_en) begin
            valid_q[bus.index] <= 1'b0;
            dirty_q[bus.index] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= CLEAR;
            clr_cnt_q     <= '0;
            rdata_valid_q <= 1'b0;
            dataout_q     <= '0;
            valid_out_q   <= 1'b0;
            dirty_out_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            rdata_valid_q <= rd_en;
            if (rd_en) begin
                dataout_q   <= mem_q[bus.index];
                valid_out_q <= valid_q[bus.index];
                dirty_out_q <= dirty_q[bus.index];
            end
        end
    end

    assign bus.rdata_valid = rdata_valid_q;
    assign bus.dataout     = dataout_q;
    assign bus.valid_out   = valid_out_q;
    assign bus.dirty_out   = dirty_out_q;
endmodule

// File: tb/tb_l2_param_array.sv
// Scoreboard bench for l2_param_array: main 128x16 instance
// plus a 64x8 instance for the small-geometry sweep.
module tb_l2_param_array;
    localparam int W  = 128;
    localparam int D  = 16;
    localparam int BW = W / 8;
    localparam int IW = 4;

    localparam int W2 = 64;
    localparam int D2 = 8;

    typedef struct packed {
        int unsigned   cyc;
        logic [W-1:0]  d;
        logic          v;
        logic          dt;
    } rd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    always #5 clk = ~clk;

    l2_param_array_if #(.WIDTH(W), .DEPTH(D)) bus ();
    l2_param_array_if #(.WIDTH(W2), .DEPTH(D2)) bus2 ();

    l2_param_array #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    l2_param_array #(.WIDTH(W2), .DEPTH(D2)) dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    rd_t exp_q[$];
    rd_t got_q[$];

    logic [W-1:0] m_data [D];
    logic         m_v [D];
    logic         m_d [D];

    always @(negedge clk) begin
        if (bus.rdata_valid === 1'b1)
            got_q.push_back('{cyc, bus.dataout, bus.valid_out, bus.dirty_out});
    end

    task automatic model_clear();
        for (int i = 0; i < D; i++) begin
            m_data[i] = '0;
            m_v[i] = 1'b0;
            m_d[i] = 1'b0;
        end
    endtask

    // Drive one request for one cycle; acc is the bench's own view of acceptance.
    task automatic issue(input bit acc, input bit wr, input bit inv,
                         input int idx, input logic [BW-1:0] be,
                         input logic [W-1:0] dat, input bit dty);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_inval = inv;
        bus.index     = idx[IW-1:0];
        bus.byte_en   = be;
        bus.datain    = dat;
        bus.dirty_in  = dty;
        if (acc) begin
            if (inv) begin
                m_v[idx] = 1'b0;
                m_d[idx] = 1'b0;
            end else if (wr) begin
                for (int b = 0; b < BW; b++)
                    if (be[b]) m_data[idx][8*b +: 8] = dat[8*b +: 8];
                m_v[idx] = 1'b1;
                m_d[idx] = dty;
            end else begin
                exp_q.push_back('{cyc + 1, m_data[idx], m_v[idx], m_d[idx]});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        bus.clear_req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int cnt;
        rd_t e, g;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.req_ready, bus.rdata_valid, bus.valid_out, bus.dirty_out, bus.dataout}
            !== {4'b0000, {W{1'b0}}}) begin
            n_bad++;
            $display("FAIL reset_outputs rdy=%b rv=%b v=%b d=%b data=%h want all 0",
                     bus.req_ready, bus.rdata_valid, bus.valid_out, bus.dirty_out, bus.dataout);
        end
        rst_n = 1'b1;
        cnt = 0;
        while (bus.req_ready !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (cnt !== 16) begin
            n_bad++;
            $display("FAIL reset_sweep_len got %0d cycles want 16", cnt);
        end
        model_clear();
        for (int i = 0; i < D; i++) issue(1, 0, 0, i, '0, '0, 0);
        idle(2);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL reset_read_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e || g.d !== '0 || g.v !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_read cyc=%0d data=%h v=%b d=%b want cyc=%0d data=0 v=0 d=0",
                         g.cyc, g.d, g.v, g.dt, e.cyc);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_write_read();
        logic [W-1:0] pat;
        rd_t e, g;
        pat = 128'h0123456789ABCDEF0123456789ABCDEF;
        issue(1, 1, 0, 3, '1, pat, 1);
        issue(1, 0, 0, 3, '0, '0, 0);
        idle(3);
        n_cmp++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            n_bad++;
            $display("FAIL wr_rd_count got %0d want 1", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e || g.d !== pat || {g.v, g.dt} !== 2'b11) begin
                n_bad++;
                $display("FAIL wr_rd cyc=%0d data=%h v=%b d=%b want cyc=%0d data=%h v=1 d=1",
                         g.cyc, g.d, g.v, g.dt, e.cyc, pat);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_byte_en();
        rd_t e, g;
        logic [W-1:0] want1;
        want1 = {{(W-8){1'b1}}, 8'h00};
        issue(1, 1, 0, 5, '1, '1, 1);
        issue(1, 1, 0, 5, 16'h0001, '0, 1);
        issue(1, 0, 0, 5, '0, '0, 0);
        issue(1, 1, 0, 5, '0, 128'h5A5A, 0);
        issue(1, 0, 0, 5, '0, '0, 0);
        idle(2);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL be_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e || g.d !== want1) begin
                n_bad++;
                $display("FAIL be_read cyc=%0d data=%h v=%b d=%b want cyc=%0d data=%h v=%b d=%b",
                         g.cyc, g.d, g.v, g.dt, e.cyc, want1, e.v, e.dt);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_inval();
        rd_t e, g;
        issue(1, 1, 1, 3, '1, '0, 1);
        issue(1, 0, 0, 3, '0, '0, 0);
        idle(2);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL inval_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e || {g.v, g.dt} !== 2'b00) begin
                n_bad++;
                $display("FAIL inval_read cyc=%0d data=%h v=%b d=%b want cyc=%0d data=%h v=0 d=0",
                         g.cyc, g.d, g.v, g.dt, e.cyc, e.d);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        rd_t e, g;
        logic [W-1:0] r;
        for (int k = 0; k < 6; k++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            issue(1, 1, 0, 8 + k, BW'($urandom), r, k[0]);
            issue(1, 0, 0, 8 + k, '0, '0, 0);
        end
        for (int k = 5; k >= 0; k--) issue(1, 0, 0, 8 + k, '0, '0, 0);
        issue(1, 0, 0, 5, '0, '0, 0);
        idle(2);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL b2b_read cyc=%0d data=%h v=%b d=%b want cyc=%0d data=%h v=%b d=%b",
                         g.cyc, g.d, g.v, g.dt, e.cyc, e.d, e.v, e.dt);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_clear_req();
        int cnt;
        rd_t e, g;
        bus.clear_req = 1'b1;
        issue(1, 0, 0, 5, '0, '0, 0);
        bus.clear_req = 1'b0;
        model_clear();
        cnt = 0;
        while (bus.req_ready !== 1'b1 && cnt < 40) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b0;
            bus.req_inval = 1'b0;
            bus.index     = 4'd5;
            @(negedge clk);
            cnt++;
        end
        bus.req_valid = 1'b0;
        n_cmp++;
        if (cnt !== 16) begin
            n_bad++;
            $display("FAIL clr_sweep_len got %0d cycles want 16", cnt);
        end
        for (int i = 0; i < D; i++) issue(1, 0, 0, i, '0, '0, 0);
        idle(2);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL clr_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL clr_read cyc=%0d data=%h v=%b d=%b want cyc=%0d data=%h v=%b d=%b",
                         g.cyc, g.d, g.v, g.dt, e.cyc, e.d, e.v, e.dt);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_sweep_restart();
        int cnt;
        rd_t e, g;
        issue(1, 1, 0, 9, '1, {4{32'hC0FFEE11}}, 1);
        issue(1, 0, 0, 9, '0, '0, 0);
        idle(2);
        bus.clear_req = 1'b1;
        @(negedge clk);
        bus.clear_req = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.rdata_valid, bus.valid_out, bus.dirty_out, bus.dataout}
            !== {3'b000, {W{1'b0}}}) begin
            n_bad++;
            $display("FAIL rst_mid_outputs rv=%b v=%b d=%b data=%h want all 0",
                     bus.rdata_valid, bus.valid_out, bus.dirty_out, bus.dataout);
        end
        rst_n = 1'b1;
        model_clear();
        cnt = 0;
        while (bus.req_ready !== 1'b1 && cnt < 40) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b1;
            bus.req_inval = 1'b0;
            bus.index     = 4'd2;
            bus.byte_en   = '1;
            bus.datain    = '1;
            bus.dirty_in  = 1'b1;
            @(negedge clk);
            cnt++;
        end
        bus.req_valid = 1'b0;
        n_cmp++;
        if (cnt !== 16) begin
            n_bad++;
            $display("FAIL restart_sweep_len got %0d cycles want 16", cnt);
        end
        issue(1, 0, 0, 2, '0, '0, 0);
        issue(1, 0, 0, 9, '0, '0, 0);
        idle(2);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL restart_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL restart_read cyc=%0d data=%h v=%b d=%b want cyc=%0d data=%h v=%b d=%b",
                         g.cyc, g.d, g.v, g.dt, e.cyc, e.d, e.v, e.dt);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_small();
        int cnt;
        rst2_n = 1'b0;
        repeat (2) @(negedge clk);
        rst2_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus2.req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL small_mid_ready got %b want 0", bus2.req_ready);
        end
        rst2_n = 1'b0;
        @(negedge clk);
        rst2_n = 1'b1;
        cnt = 0;
        while (bus2.req_ready !== 1'b1 && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (cnt !== 8) begin
            n_bad++;
            $display("FAIL small_sweep_len got %0d cycles want 8", cnt);
        end
        bus2.req_valid = 1'b1;
        bus2.req_write = 1'b1;
        bus2.index     = 3'd6;
        bus2.byte_en   = 8'hF0;
        bus2.datain    = 64'hAAAAAAAA_BBBBBBBB;
        bus2.dirty_in  = 1'b0;
        @(negedge clk);
        bus2.req_write = 1'b0;
        @(negedge clk);
        bus2.req_valid = 1'b0;
        n_cmp++;
        if ({bus2.rdata_valid, bus2.valid_out, bus2.dirty_out, bus2.dataout}
            !== {3'b110, 64'hAAAAAAAA_00000000}) begin
            n_bad++;
            $display("FAIL small_read rv=%b v=%b d=%b data=%h want rv=1 v=1 d=0 data=aaaaaaaa00000000",
                     bus2.rdata_valid, bus2.valid_out, bus2.dirty_out, bus2.dataout);
        end
        @(negedge clk);
        n_cmp++;
        if (bus2.rdata_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL small_pulse rv=%b want 0", bus2.rdata_valid);
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_inval  = 1'b0;
        bus.index      = '0;
        bus.byte_en    = '0;
        bus.datain     = '0;
        bus.dirty_in   = 1'b0;
        bus.clear_req  = 1'b0;
        bus2.req_valid = 1'b0;
        bus2.req_write = 1'b0;
        bus2.req_inval = 1'b0;
        bus2.index     = '0;
        bus2.byte_en   = '0;
        bus2.datain    = '0;
        bus2.dirty_in  = 1'b0;
        bus2.clear_req = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_en();
        test_inval();
        test_back_to_back();
        test_clear_req();
        test_sweep_restart();
        test_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
